sort_index: RTL and testbench

- Sequential odd-even transposition sorter feeding the unsort stage.
- Captures SIZE words and sorts them ascending.
- Emits the sorted words together with each word's original position (permutation vector).
- index_out is defined so that writing data_out[k] to position index_out[k] restores the original order. Sort → process → unsort round-trips.

---
 rtl/sort_index.sv | 100 ++++++++++
 tb/tb_sort_index.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/sort_index.sv
// rtl/sort_index.sv - odd-even transposition sorter emitting sorted words plus their original positions (SORTER_SIGNED_EN selects signed compare)
module sort_index #(
    parameter int SIZE          = 4,
    parameter int NETWORK_WIDTH = 8,
    parameter int INDEX_WIDTH   = 2
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    start,
    input  logic [SIZE-1:0][NETWORK_WIDTH-1:0]      data_in,
    output logic [SIZE-1:0][NETWORK_WIDTH-1:0]      data_out,
    output logic [SIZE-1:0][INDEX_WIDTH-1:0]        index_out,
    output logic                                    busy,
    output logic                                    done
);

    localparam int PW = $clog2(SIZE + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                                 state_q;
    logic [PW-1:0]                          phase_q;
    logic [SIZE-1:0][NETWORK_WIDTH-1:0]     data_q, data_d;
    logic [SIZE-1:0][INDEX_WIDTH-1:0]       idx_q, idx_d;
    logic                                   busy_q, done_q;
    logic                                   odd;
    logic                                   gt;

    // One compare-exchange phase; pairs are disjoint so they all read the registered values.
    always_comb begin
        data_d = data_q;
        idx_d  = idx_q;
        odd    = phase_q[0];
        gt     = 1'b0;
        for (int k = 0; k < SIZE - 1; k++) begin
            if ((k % 2) == int'(odd)) begin
`ifdef SORTER_SIGNED_EN
                gt = $signed(data_q[k]) > $signed(data_q[k+1]);
`else
                gt = data_q[k] > data_q[k+1];
`endif
                if (gt) begin
                    data_d[k]   = data_q[k+1];
                    data_d[k+1] = data_q[k];
                    idx_d[k]    = idx_q[k+1];
                    idx_d[k+1]  = idx_q[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            phase_q <= '0;
            data_q  <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        data_q <= data_in;
                        for (int k = 0; k < SIZE; k++) begin
                            idx_q[k] <= INDEX_WIDTH'(k);
                        end
                        phase_q <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        state_q <= SORT;
                    end
                end
                SORT: begin
                    data_q  <= data_d;
                    idx_q   <= idx_d;
                    phase_q <= phase_q + PW'(1);
                    if (phase_q == PW'(SIZE - 1)) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign data_out  = data_q;
    assign index_out = idx_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_sort_index.sv
// tb/tb_sort_index.sv - directed table-driven bench for sort_index (SIZE=4, 8-bit words)
module tb_sort_index;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [3:0][7:0]   data_in;
    logic [3:0][7:0]   data_out;
    logic [3:0][1:0]   index_out;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;

    sort_index #(.SIZE(4), .NETWORK_WIDTH(8), .INDEX_WIDTH(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .data_in   (data_in),
        .data_out  (data_out),
        .index_out (index_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] din;
        logic [31:0] dout;
        logic [7:0]  idx;
    } vec_t;

    function automatic logic [31:0] pk(input logic [7:0] a0, a1, a2, a3);
        return {a3, a2, a1, a0};
    endfunction

    function automatic logic [7:0] pi(input logic [1:0] i0, i1, i2, i3);
        return {i3, i2, i1, i0};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    // Pulse start for one cycle, then count edges from the accepting edge until done.
    task automatic run_sort(input logic [31:0] d, output int lat, output int bcyc);
        @(negedge clk);
        data_in = d;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("accept_busy", 32'(busy), 32'd1);
        chk("accept_done", 32'(done), 32'd0);
        lat  = 1;
        bcyc = 0;
        while (!done && lat < 20) begin
            if (busy) bcyc++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    vec_t vecs[5];
    int   lat, bcyc;
    logic [7:0] rest [4];
    logic [31:0] restp;

    initial begin
        vecs[0] = '{"t1_basic",  pk(3,1,2,0), pk(0,1,2,3), pi(3,1,2,0)};
        vecs[1] = '{"t2_stable", pk(2,1,2,1), pk(1,1,2,2), pi(1,3,0,2)};
        vecs[2] = '{"t2_equal",  pk(5,5,5,5), pk(5,5,5,5), pi(0,1,2,3)};
        vecs[3] = '{"t3_worst",  pk(3,2,1,0), pk(0,1,2,3), pi(3,2,1,0)};
`ifdef SORTER_SIGNED_EN
        vecs[4] = '{"t6_sign",   pk(8'h80,8'h01,8'hFF,8'h00), pk(8'h80,8'hFF,8'h00,8'h01), pi(0,2,3,1)};
`else
        vecs[4] = '{"t6_sign",   pk(8'h80,8'h01,8'hFF,8'h00), pk(8'h00,8'h01,8'h80,8'hFF), pi(3,1,0,2)};
`endif

        reset   = 1'b1;
        start   = 1'b1;
        data_in = pk(7,7,7,7);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_data",  data_out, 32'h0);
        chk("reset_idx",   32'(index_out), 32'h0);
        chk("reset_busy",  32'(busy), 32'd0);
        chk("reset_done",  32'(done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_sort(vecs[i].din, lat, bcyc);
            chk({vecs[i].name, "_lat"},  32'(lat), 32'd5);
            chk({vecs[i].name, "_busy"}, 32'(bcyc), 32'd4);
            chk({vecs[i].name, "_data"}, data_out, vecs[i].dout);
            chk({vecs[i].name, "_idx"},  32'(index_out), 32'(vecs[i].idx));
            chk({vecs[i].name, "_bsy0"}, 32'(busy), 32'd0);
            if (i == 3) begin
                for (int k = 0; k < 4; k++) rest[index_out[k]] = data_out[k];
                restp = {rest[3], rest[2], rest[1], rest[0]};
                chk("t3_unsort", restp, pk(3,2,1,0));
            end
        end

        // Start during SORT is ignored.
        @(negedge clk);
        data_in = pk(3,1,2,0);
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        data_in = pk(9,9,9,1);
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        data_in = pk(4,4,4,4);
        lat = 2;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("t4_ign_lat",  32'(lat), 32'd5);
        chk("t4_ign_data", data_out, pk(0,1,2,3));
        chk("t4_ign_idx",  32'(index_out), 32'(pi(3,1,2,0)));
        repeat (2) @(posedge clk);
        #1;
        chk("t4_hold_done", 32'(done), 32'd1);
        chk("t4_hold_data", data_out, pk(0,1,2,3));

        run_sort(pk(9,8,7,6), lat, bcyc);
        chk("t4_restart_lat",  32'(lat), 32'd5);
        chk("t4_restart_data", data_out, pk(6,7,8,9));
        chk("t4_restart_idx",  32'(index_out), 32'(pi(3,2,1,0)));

        // Reset during phase 2 aborts the sort.
        @(negedge clk);
        data_in = pk(3,2,1,0);
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("t5_rst_data", data_out, 32'h0);
        chk("t5_rst_idx",  32'(index_out), 32'h0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_done", 32'(done), 32'd0);
        run_sort(pk(3,1,2,0), lat, bcyc);
        chk("t5_after_lat",  32'(lat), 32'd5);
        chk("t5_after_data", data_out, pk(0,1,2,3));
        chk("t5_after_idx",  32'(index_out), 32'(pi(3,1,2,0)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
